regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port _Reset, input, 1, reset: synchronous, active-low, sampled on the CLK rising edge.
REQ-003 SHALL have ports a_valid/b_valid, input, 1 each, writeback request from ALU (A) / load unit (B).
REQ-004 SHALL have ports a_ready/b_ready, output, 1 each, grant; combinational from current state and valids.
REQ-005 SHALL have ports a_rd/b_rd, input, 5 each, destination register; a_data/b_data, input, 32 each, write data.
REQ-006 SHALL have ports issue_valid, input, 1, and issue_rd, input, 5: marks the destination of a newly issued instruction pending.
REQ-007 SHALL have ports rs1/rs2, input, 5 each, operand query; hazard_1/hazard_2, output, 1 each, operand is pending.
REQ-008 SHALL have ports rf_we, output, 1; rf_waddr, output, 5; rf_wdata, output, 32: registered regfile write port.
REQ-009 SHALL have port pending, output, 32, scoreboard bitmap, bit n = register n awaiting writeback.

Function
REQ-010 SHALL accept a request on the cycle valid&&ready is high (a "transfer"); at most one transfer per cycle.
REQ-011 SHALL assert ready for exactly one requester when any valid is high, none when neither is.
REQ-012 SHALL arbitrate round-robin: state bit last_grant (0=A,1=B); on contention grant the non-last requester; single requester always granted.
REQ-013 SHALL update last_grant only on a transfer.
REQ-014 SHALL present each transfer on rf_we/rf_waddr/rf_wdata on the cycle after the transfer (latency 1); rf_we low otherwise.
REQ-015 SHALL consume a transfer with rd=0 but keep rf_we low and leave pending unchanged.
REQ-016 SHALL set pending[issue_rd] on the cycle after issue_valid when issue_rd!=0; issue_rd=0 ignored.
REQ-017 SHALL clear pending[rd] on the cycle after a transfer to rd.
REQ-018 SHALL keep the bit set when set and clear target the same register in one cycle (new issue wins).
REQ-019 SHALL drive hazard_n = pending[rsn] combinationally, masked low if a same-cycle transfer targets rsn (forwarding handled elsewhere); hazard for rs=0 always 0.
REQ-020 SHALL treat requester protocol as: once valid is high, rd/data stable and valid held until transfer; arbiter need not tolerate violations.
REQ-021 SHALL guarantee a continuously valid requester a transfer within 2 cycles.
REQ-022 SHALL not allocate or reorder: no buffering beyond the output register.

Reset
REQ-023 SHALL, while _Reset=0 at a CLK edge, clear pending to 0, last_grant to 1 (A wins first contention), rf_we/rf_waddr/rf_wdata to 0.
REQ-024 SHALL hold a_ready/b_ready low while _Reset=0; no transfer occurs during reset.
REQ-025 SHALL discard any transfer or issue coinciding with an active reset cycle; first transfer possible the cycle reset deasserts.

Structure
REQ-026 SHALL place constants REG_COUNT=32, REG_ADDR_W=5, XLEN=32 and requester IDs GRANT_A/GRANT_B in shared package rv32i_pkg.
REQ-027 SHALL implement the pending bitmap as one sub-module regfile_scoreboard (set port, clear port, two query ports); arbitration and output register in the top.

Verification
REQ-028 SHALL cover: reset, then a_valid=1,a_rd=5,a_data=32'h1234 alone -> a_ready=1 same cycle, next cycle rf_we=1,rf_waddr=5,rf_wdata=32'h1234.
REQ-029 SHALL cover: a_valid and b_valid held 4 cycles after reset -> grants A,B,A,B; each rf write one cycle later in the same order.
REQ-030 SHALL cover: issue_rd=7, then rs1=7 -> hazard_1=1, pending[7]=1; b transfer rd=7 -> hazard_1=0 same cycle, pending[7]=0 next cycle.
REQ-031 SHALL cover: issue_rd=9 and transfer rd=9 same cycle with pending[9]=1 -> pending[9] remains 1.
REQ-032 SHALL cover: transfer rd=0 data=32'hFFFFFFFF -> ready=1, rf_we stays 0; issue_rd=0 -> pending stays 0.
REQ-033 SHALL cover: _Reset=0 mid-contention with pending=32'h00000F00 -> next cycle pending=0, rf_we=0, readies low; after release A wins contention.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared register-file constants and writeback requester IDs
package rv32i_pkg;
    localparam int REG_COUNT = 32;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN = 32;
    typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-writeback bitmap with one set, one clear and two query ports
module regfile_scoreboard
    import rv32i_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    input  logic [REG_ADDR_W-1:0] q1_idx,
    input  logic [REG_ADDR_W-1:0] q2_idx,
    output logic                  q1_hit,
    output logic                  q2_hit,
    output logic [REG_COUNT-1:0]  pending
);
    logic [REG_COUNT-1:0] set_mask;
    logic [REG_COUNT-1:0] clr_mask;
    assign set_mask = REG_COUNT'(set_en) << set_idx;
    assign clr_mask = REG_COUNT'(clr_en) << clr_idx;
    assign q1_hit = pending[q1_idx];
    assign q2_hit = pending[q2_idx];
    // Set is applied after clear so a new issue wins; x0 is never tracked.
    always_ff @(posedge clk)
        pending <= !rst_n ? '0 : ((pending & ~clr_mask) | set_mask) & ~REG_COUNT'(1);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin ALU/load writeback arbiter with registered regfile write and hazard scoreboard
module regfile_wb_arbiter
    import rv32i_pkg::*;
(
    input  logic                  CLK,
    input  logic                  _Reset,
    input  logic                  a_valid,
    input  logic                  b_valid,
    output logic                  a_ready,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [XLEN-1:0]       a_data,
    input  logic [XLEN-1:0]       b_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard_1,
    output logic                  hazard_2,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [REG_COUNT-1:0]  pending
);
    grant_e                last_grant;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] xfer_rd;
    logic [XLEN-1:0]       xfer_data;
    logic                  hit_1;
    logic                  hit_2;
    // On contention the requester that did not win last time is granted.
    assign a_ready = _Reset && a_valid && (!b_valid || last_grant == GRANT_B);
    assign b_ready = _Reset && b_valid && (!a_valid || last_grant == GRANT_A);
    assign xfer = a_ready || b_ready;
    assign xfer_rd = a_ready ? a_rd : b_rd;
    assign xfer_data = a_ready ? a_data : b_data;
    assign hazard_1 = hit_1 && !(xfer && xfer_rd == rs1);
    assign hazard_2 = hit_2 && !(xfer && xfer_rd == rs2);
    always_ff @(posedge CLK) begin
        if (!_Reset) begin
            last_grant <= GRANT_B;
            rf_we <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= xfer && xfer_rd != '0;
            if (xfer) begin
                last_grant <= b_ready ? GRANT_B : GRANT_A;
                rf_waddr <= xfer_rd;
                rf_wdata <= xfer_data;
            end
        end
    end
    regfile_scoreboard u_sb (
        .clk     (CLK),
        .rst_n   (_Reset),
        .set_en  (issue_valid),
        .set_idx (issue_rd),
        .clr_en  (xfer),
        .clr_idx (xfer_rd),
        .q1_idx  (rs1),
        .q2_idx  (rs2),
        .q1_hit  (hit_1),
        .q2_hit  (hit_2),
        .pending (pending)
    );
endmodule
